// File: rtl/gpio_display_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_display_arbiter_if
//  Description : Requester/display bundle for the GPIO display arbiter.
//                master = requester side, slave = arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gpio_display_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]     req;
   logic [NREQ*128-1:0] src_rows;
   logic [NREQ*64-1:0]  src_hex;
   logic [NREQ-1:0]     grant;
   logic [1:0]          owner;
   logic [127:0]        rows_out;
   logic [63:0]         hex_out;
   logic                busy;

   modport master (
      output req, src_rows, src_hex,
      input  grant, owner, rows_out, hex_out, busy
   );

   modport slave (
      input  req, src_rows, src_hex,
      output grant, owner, rows_out, hex_out, busy
   );
endinterface
`default_nettype wire

// File: rtl/gpio_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_display_arbiter
//  Description : Round-robin owner of the GPIO display (LED rows + 7-seg
//                digits) with minimum dwell under contention and a blanked
//                guard interval between owners. Optional macro
//                PRIORITY_OVERRIDE_EN gives requester 0 preemptive priority.
//                NREQ must match the NREQ of the connected interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpio_display_arbiter #(
   parameter int NREQ         = 4,
   parameter int DWELL_CYCLES = 50000000,
   parameter int GUARD_CYCLES = 4096,
   parameter int CNT_W        = 26
) (
   input  logic                   clock_50,
   input  logic                   reset_n,
   gpio_display_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_OWN   = 2'd1,
      S_GUARD = 2'd2
   } state_t;

   localparam logic [1:0]       LAST_INIT  = 2'(NREQ - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

   state_t            state;
   logic [1:0]        last;
   logic [CNT_W-1:0]  dwell;
   logic [CNT_W-1:0]  guard_cnt;
   logic [NREQ-1:0]   grant_q;
   logic [1:0]        owner_q;
   logic              busy_q;
   logic [127:0]      rows_q;
   logic [63:0]       hex_q;

   logic              pick_valid;
   logic [1:0]        pick_idx;
   logic              owner_req;
   logic              other_req;
   logic              preempt;

   // Next owner: first active request after the last owner, wrapping; the
   // loop runs backwards so the nearest candidate is assigned last and wins.
   always_comb begin
      pick_valid = 1'b0;
      pick_idx   = 2'd0;
      for (int k = NREQ; k >= 1; k--) begin
         if (bus.req[(int'(last) + k) % NREQ]) begin
            pick_valid = 1'b1;
            pick_idx   = 2'((int'(last) + k) % NREQ);
         end
      end
`ifdef PRIORITY_OVERRIDE_EN
      if (bus.req[0]) begin
         pick_valid = 1'b1;
         pick_idx   = 2'd0;
      end
`endif
   end

   assign owner_req = bus.req[owner_q];
   // grant_q is one-hot on the owner while in OWN, so this masks the owner out
   assign other_req = |(bus.req & ~grant_q);

`ifdef PRIORITY_OVERRIDE_EN
   assign preempt = (owner_q != 2'd0) && bus.req[0];
`else
   assign preempt = 1'b0;
`endif

   // Ownership FSM with registered grant/owner/busy and the display datapath
   always_ff @(posedge clock_50) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         last      <= LAST_INIT;
         dwell     <= '0;
         guard_cnt <= '0;
         grant_q   <= '0;
         owner_q   <= 2'd0;
         busy_q    <= 1'b0;
         rows_q    <= '0;
         hex_q     <= '0;
      end else begin
         // Data follows the owner one cycle behind the state
         if (state == S_OWN) begin
            rows_q <= bus.src_rows[int'(owner_q)*128 +: 128];
            hex_q  <= bus.src_hex[int'(owner_q)*64 +: 64];
         end else begin
            rows_q <= '0;
            hex_q  <= '0;
         end

         case (state)
            S_IDLE: begin
               if (pick_valid) begin
                  state   <= S_OWN;
                  grant_q <= NREQ'(1) << pick_idx;
                  owner_q <= pick_idx;
                  last    <= pick_idx;
                  dwell   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            S_OWN: begin
               if (dwell != DWELL_LAST) begin
                  dwell <= dwell + 1'b1;
               end
               if (!owner_req || preempt || ((dwell == DWELL_LAST) && other_req)) begin
                  state     <= S_GUARD;
                  grant_q   <= '0;
                  busy_q    <= 1'b0;
                  guard_cnt <= '0;
               end
            end
            S_GUARD: begin
               if (guard_cnt == GUARD_LAST) begin
                  if (pick_valid) begin
                     state   <= S_OWN;
                     grant_q <= NREQ'(1) << pick_idx;
                     owner_q <= pick_idx;
                     last    <= pick_idx;
                     dwell   <= '0;
                     busy_q  <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  guard_cnt <= guard_cnt + 1'b1;
               end
            end
            default: begin
               state   <= S_IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.grant    = grant_q;
   assign bus.owner    = owner_q;
   assign bus.busy     = busy_q;
   assign bus.rows_out = rows_q;
   assign bus.hex_out  = hex_q;

endmodule
`default_nettype wire
